// File: rtl/min_scan_ctrl_if.sv
// min_scan_ctrl_if: query-side handshake, comparator link and result bus of min_scan_ctrl.
interface min_scan_ctrl_if #(
  parameter int D_W   = 10,
  parameter int IDX_W = 6
);
  logic               start;
  logic [IDX_W:0]     cand_num;
  logic               in_valid;
  logic               in_ready;
  logic [D_W-1:0]     in_dist;
  logic [8*D_W-1:0]   mn_d;
  logic [2:0]         mn_index;
  logic [D_W-1:0]     mn_distance;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   best_idx;
  logic [D_W-1:0]     best_dist;

  modport master (
    input  start, cand_num, in_valid, in_dist, mn_index, mn_distance,
    output in_ready, mn_d, busy, done, best_idx, best_dist
  );

  modport slave (
    output start, cand_num, in_valid, in_dist, mn_index, mn_distance,
    input  in_ready, mn_d, busy, done, best_idx, best_dist
  );
endinterface

// File: rtl/min_scan_ctrl.sv
// min_scan_ctrl: packs distances into 8-wide batches for a min comparator, keeps a running best (MIN_SCAN_REG_OUT_EN adds a WAIT stage).
// Latency: k fill cycles + 1 compare per batch (+1 WAIT per batch with the macro), then a 1-cycle done pulse.
// Backpressure: in_ready only in FILL; in_valid gaps stall filling without loss.
module min_scan_ctrl #(
  parameter int D_W      = 10,
  parameter int CAND_MAX = 64,
  parameter int IDX_W    = 6
) (
  input  logic            clk,
  input  logic            reset,
  min_scan_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [D_W-1:0] PAD   = '1;
  localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(CAND_MAX);

  logic [2:0]       state;
  logic [IDX_W:0]   n_r;
  logic [IDX_W:0]   total;
  logic [IDX_W:0]   total_nxt;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] base;
  logic             first_done;
  logic [D_W-1:0]   slot [8];
  logic [IDX_W-1:0] best_idx_r;
  logic [D_W-1:0]   best_dist_r;
  logic [2:0]       sel_index;
  logic [D_W-1:0]   sel_dist;
  logic             take;

`ifdef MIN_SCAN_REG_OUT_EN
  localparam logic [2:0] S_UPD = S_WAIT;
  logic [2:0]     mn_index_q;
  logic [D_W-1:0] mn_distance_q;

  // Comparator result is captured at the end of CMP so the best-register update sees a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mn_index_q    <= '0;
      mn_distance_q <= '0;
    end else if (state == S_CMP) begin
      mn_index_q    <= bus.mn_index;
      mn_distance_q <= bus.mn_distance;
    end
  end

  assign sel_index = mn_index_q;
  assign sel_dist  = mn_distance_q;
`else
  localparam logic [2:0] S_UPD = S_CMP;
  assign sel_index = bus.mn_index;
  assign sel_dist  = bus.mn_distance;
`endif

  assign total_nxt = total + 1'b1;
  // The first batch loads unconditionally; later batches need a strict win so earlier ones keep ties.
  assign take      = !first_done || (sel_dist < best_dist_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      n_r         <= '0;
      total       <= '0;
      cnt         <= '0;
      base        <= '0;
      first_done  <= 1'b0;
      best_idx_r  <= '0;
      best_dist_r <= '0;
      for (int k = 0; k < 8; k++) slot[k] <= PAD;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_r         <= (bus.cand_num > N_MAX) ? N_MAX : bus.cand_num;
            total       <= '0;
            cnt         <= '0;
            base        <= '0;
            first_done  <= 1'b0;
            best_idx_r  <= '0;
            best_dist_r <= PAD;
            for (int k = 0; k < 8; k++) slot[k] <= PAD;
            state <= (bus.cand_num == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            slot[cnt[2:0]] <= bus.in_dist;
            cnt            <= cnt + 4'd1;
            total          <= total_nxt;
            if (cnt == 4'd7 || total_nxt == n_r) state <= S_CMP;
          end
        end
        S_CMP, S_WAIT: begin
          if (state == S_UPD) begin
            first_done <= 1'b1;
            if (take) begin
              best_dist_r <= sel_dist;
              best_idx_r  <= base + IDX_W'(sel_index);
            end
            if (total < n_r) begin
              base  <= base + IDX_W'(8);
              cnt   <= '0;
              for (int k = 0; k < 8; k++) slot[k] <= PAD;
              state <= S_FILL;
            end else begin
              state <= S_DONE;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mn_d = '1;
    for (int k = 0; k < 8; k++) bus.mn_d[k*D_W +: D_W] = slot[k];
  end

  assign bus.in_ready  = (state == S_FILL);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.best_idx  = best_idx_r;
  assign bus.best_dist = best_dist_r;
endmodule

// File: doc/min_scan_ctrl.md
# min_scan_ctrl

Sequencing controller for the 8-input minimum-distance comparator. It accepts a stream of Manhattan distances for one query and packs them into 8-wide batches. Each batch goes to the comparator, and a running global minimum is kept across batches. When the last candidate has been compared, it reports the winning candidate index and its distance. It sits between the distance-computation stage and the result consumer.

## Interface
- D_W, 10, distance width (matches the comparator data size)
- CAND_MAX, 64, maximum candidates per search
- IDX_W, 6, width of global candidate index (log2 CAND_MAX)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin search; sampled only in IDLE
- cand_num  in  IDX_W+1  candidate count N for this search, latched on start
- in_valid  in  1  in_dist valid
- in_ready  out  1  controller accepts in_dist this cycle
- in_dist  in  D_W  candidate distance, candidates arrive in index order 0..N-1
- mn_d  out  8*D_W  comparator inputs; slot k at bits [k*D_W +: D_W]
- mn_index  in  3  comparator winning slot
- mn_distance  in  D_W  comparator winning distance
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, result valid
- best_idx  out  IDX_W  global index of minimum
- best_dist  out  D_W  minimum distance

## Operation
- States: IDLE, FILL, CMP, WAIT (only with the macro), DONE.
- IDLE:
  - start=1 latches N, clears slot counter and batch base, sets the running best to {all ones, idx 0}, and clears the first-batch flag.
  - If N=0, go to DONE with best_dist=all ones and best_idx=0.
  - Otherwise go to FILL.
- FILL:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_dist into slot[cnt], then increments cnt and the accepted total.
  - Go to CMP once 8 slots are filled or the total reaches N.
- On entering CMP, unfilled slots hold all ones (pad). The comparator's lower-index tie rule means real entries always beat pads of equal value.
- CMP, or WAIT with the macro, compares mn_distance with best_dist. The comparison is strict (<), or the first batch of the search is being compared; either condition loads best_dist=mn_distance and best_idx=base+mn_index. Earlier batches therefore win ties.
- After the compare: if total<N, base+=8, cnt=0, refill slots with all ones, and go to FILL. Otherwise go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - best_idx and best_dist hold until the next accepted start.
- start is ignored while busy. in_dist is ignored outside FILL.
- Index arithmetic: base+mn_index, truncated to IDX_W bits. cand_num>CAND_MAX saturates to CAND_MAX.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, busy=0, done=0
  - best_idx=0, best_dist=0
  - mn_d=all ones
- Reset asserted mid-search aborts immediately. No done is produced, and the next search needs a new start.
- start high in IDLE at edge t gives FILL from t+1.
- With in_valid held high, one candidate is accepted per cycle.
- Per batch: k fill cycles plus 1 compare cycle (plus 1 WAIT with the macro).
- Example: N=8 with continuous valid accepts in cycles t+1..t+8, CMP at t+9, done high in t+10 (t+11 with the macro).
- in_valid gaps stall FILL without data loss. The accepted stream is unaffected by gaps.
- in_ready is 0 in CMP, WAIT and DONE.

## Configuration
- MIN_SCAN_REG_OUT_EN defined:
  - mn_index and mn_distance are registered at the end of CMP.
  - The compare/update happens in the WAIT state one cycle later.
  - Each batch costs +1 cycle, and the comparator path is cut from the best-register update.
- Undefined:
  - No WAIT state; the update happens combinationally from the comparator outputs in CMP.

## Test plan
- N=8, distances [50,20,30,20,99,70,40,60] -> best_idx=1, best_dist=20, done at t+10 (t+11 with the macro).
- N=20, all 500 except candidate 17=3 -> best_idx=17, best_dist=3; three batches, the last padded with 4 pad slots.
- N=16, candidate 3=5 and candidate 11=5, others 800 -> best_idx=3 (cross-batch tie keeps the earlier batch).
- N=3, all 1023 -> best_idx=0, best_dist=1023 (real entries beat pads); N=0 -> done at t+1 with best_dist=1023, best_idx=0.
- N=8 with in_valid toggling 1/0 and start pulsed while busy -> same result as the gap-free run, second start ignored, exactly one done pulse.
- reset asserted after 5 accepted candidates -> all outputs return to reset values immediately, no done; a new start with N=8 yields the correct result.
